// File: rtl/eip_chain_checker.sv
// Checks that a stream of trace steps forms a consistent EIP chain:
// every step's EIP must equal the next_eip the CFU produced for the step before it.
module eip_chain_checker #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      init_eip,
  input  logic             clear,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [31:0]      step_eip,
  input  logic [31:0]      step_next_eip,
  input  logic             step_last,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [31:0]      fault_expected,
  output logic [31:0]      fault_actual,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state_q;
  logic [31:0]      expected_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;
  logic [31:0]      fault_expected_q;
  logic [31:0]      fault_actual_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The step counter saturates at all-ones instead of wrapping.
  assign count_d    = (&count_q) ? count_q : count_q + 1'b1;
  assign step_ready = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      expected_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      fault_q          <= 1'b0;
      fault_expected_q <= '0;
      fault_actual_q   <= '0;
      count_q          <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q          <= RUN;
            expected_q       <= init_eip;
            count_q          <= '0;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            fault_expected_q <= '0;
            fault_actual_q   <= '0;
          end else if (clear && state_q == DONE) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (step_valid) begin
            count_q <= count_d;
            // A mismatch takes priority over step_last.
            if (step_eip != expected_q) begin
              state_q          <= FAULT;
              busy_q           <= 1'b0;
              fault_q          <= 1'b1;
              fault_expected_q <= expected_q;
              fault_actual_q   <= step_eip;
            end else if (step_last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              expected_q <= step_next_eip;
            end
          end
        end
        FAULT: begin
          if (clear) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign fault          = fault_q;
  assign fault_expected = fault_expected_q;
  assign fault_actual   = fault_actual_q;
  assign step_count     = count_q;

endmodule

// File: tb/tb_eip_chain_checker.sv
// Directed bench for eip_chain_checker; a second instance with a 2-bit counter
// shares the same stimulus to exercise counter saturation.
module tb_eip_chain_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] initEip;
  logic        clear;
  logic        stepValid;
  logic [31:0] stepEip;
  logic [31:0] stepNextEip;
  logic        stepLast;

  logic        stepReady, busy, done, fault;
  logic [31:0] faultExpected, faultActual, stepCount;

  logic        stepReady2, busy2, done2, fault2;
  logic [31:0] faultExpected2, faultActual2;
  logic [1:0]  stepCount2;

  int errors = 0;
  int checks = 0;

  eip_chain_checker #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_eip(initEip), .clear(clear),
    .step_valid(stepValid), .step_ready(stepReady), .step_eip(stepEip),
    .step_next_eip(stepNextEip), .step_last(stepLast), .busy(busy), .done(done),
    .fault(fault), .fault_expected(faultExpected), .fault_actual(faultActual),
    .step_count(stepCount)
  );

  eip_chain_checker #(.CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .start(start), .init_eip(initEip), .clear(clear),
    .step_valid(stepValid), .step_ready(stepReady2), .step_eip(stepEip),
    .step_next_eip(stepNextEip), .step_last(stepLast), .busy(busy2), .done(done2),
    .fault(fault2), .fault_expected(faultExpected2), .fault_actual(faultActual2),
    .step_count(stepCount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] eip, input logic [31:0] nextEip,
                               input logic last);
    stepValid   = 1'b1;
    stepEip     = eip;
    stepNextEip = nextEip;
    stepLast    = last;
    tick();
    stepValid   = 1'b0;
    stepLast    = 1'b0;
  endtask

  task automatic pulseStart(input logic [31:0] eip);
    start   = 1'b1;
    initEip = eip;
    tick();
    start   = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    initEip     = '0;
    clear       = 1'b0;
    stepValid   = 1'b0;
    stepEip     = '0;
    stepNextEip = '0;
    stepLast    = 1'b0;

    // Reset state
    #3;
    checkOutput("reset_busy",  32'(busy), 32'h0);
    checkOutput("reset_done",  32'(done), 32'h0);
    checkOutput("reset_fault", 32'(fault), 32'h0);
    checkOutput("reset_ready", 32'(stepReady), 32'h0);
    checkOutput("reset_fexp",  faultExpected, 32'h0);
    checkOutput("reset_fact",  faultActual, 32'h0);
    checkOutput("reset_count", stepCount, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] nominal chain");
    pulseStart(32'h1000);
    checkOutput("nom_busy",   32'(busy), 32'h1);
    checkOutput("nom_ready",  32'(stepReady), 32'h1);
    checkOutput("nom_count0", stepCount, 32'h0);
    applyStimulus(32'h1000, 32'h1003, 1'b0);
    applyStimulus(32'h1003, 32'h1010, 1'b0);
    checkOutput("nom_count2", stepCount, 32'h2);
    checkOutput("nom_done_early", 32'(done), 32'h0);
    applyStimulus(32'h1010, 32'h2000, 1'b1);
    checkOutput("nom_done",  32'(done), 32'h1);
    checkOutput("nom_fault", 32'(fault), 32'h0);
    checkOutput("nom_busy_end", 32'(busy), 32'h0);
    checkOutput("nom_ready_end", 32'(stepReady), 32'h0);
    checkOutput("nom_count3", stepCount, 32'h3);
    pulseClear();
    checkOutput("nom_clear_done", 32'(done), 32'h0);

    $display("[TB] mismatch");
    pulseStart(32'h1000);
    applyStimulus(32'h1000, 32'h1005, 1'b0);
    applyStimulus(32'h1006, 32'h1111, 1'b0);
    checkOutput("mm_fault", 32'(fault), 32'h1);
    checkOutput("mm_fexp",  faultExpected, 32'h1005);
    checkOutput("mm_fact",  faultActual, 32'h1006);
    checkOutput("mm_count", stepCount, 32'h2);
    checkOutput("mm_ready", 32'(stepReady), 32'h0);
    applyStimulus(32'h1005, 32'h1020, 1'b0);
    checkOutput("mm_count_hold", stepCount, 32'h2);
    checkOutput("mm_fact_hold",  faultActual, 32'h1006);
    pulseStart(32'h0005);
    checkOutput("mm_start_ignored", 32'(fault), 32'h1);
    checkOutput("mm_start_busy",    32'(busy), 32'h0);
    pulseClear();
    checkOutput("mm_clear_fault", 32'(fault), 32'h0);
    checkOutput("mm_clear_fexp",  faultExpected, 32'h1005);
    checkOutput("mm_clear_count", stepCount, 32'h2);

    $display("[TB] mismatch on last step");
    pulseStart(32'h1000);
    applyStimulus(32'h0FFF, 32'h0, 1'b1);
    checkOutput("ml_fault", 32'(fault), 32'h1);
    checkOutput("ml_done",  32'(done), 32'h0);
    checkOutput("ml_fexp",  faultExpected, 32'h1000);
    checkOutput("ml_fact",  faultActual, 32'h0FFF);
    pulseClear();

    $display("[TB] backpressure and gaps");
    pulseStart(32'h2000);
    applyStimulus(32'h2000, 32'h2004, 1'b0);
    checkOutput("bp_count1", stepCount, 32'h1);
    start   = 1'b1;
    clear   = 1'b1;
    initEip = 32'h9999;
    stepEip = 32'hDEAD;
    tick();
    start = 1'b0;
    clear = 1'b0;
    checkOutput("bp_gap_count", stepCount, 32'h1);
    checkOutput("bp_gap_busy",  32'(busy), 32'h1);
    tick();
    checkOutput("bp_gap2_fault", 32'(fault), 32'h0);
    applyStimulus(32'h2004, 32'h2008, 1'b0);
    checkOutput("bp_count2", stepCount, 32'h2);
    applyStimulus(32'h2008, 32'h200C, 1'b1);
    checkOutput("bp_done",   32'(done), 32'h1);
    checkOutput("bp_count3", stepCount, 32'h3);

    $display("[TB] control race and reset mid-run");
    start   = 1'b1;
    clear   = 1'b1;
    initEip = 32'h40;
    tick();
    start = 1'b0;
    clear = 1'b0;
    checkOutput("race_busy",  32'(busy), 32'h1);
    checkOutput("race_done",  32'(done), 32'h0);
    checkOutput("race_count", stepCount, 32'h0);
    applyStimulus(32'h40, 32'h44, 1'b0);
    checkOutput("race_step", stepCount, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy",  32'(busy), 32'h0);
    checkOutput("rst_ready", 32'(stepReady), 32'h0);
    checkOutput("rst_count", stepCount, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_idle_busy", 32'(busy), 32'h0);

    $display("[TB] saturation");
    pulseStart(32'h10);
    applyStimulus(32'h10, 32'h14, 1'b0);
    applyStimulus(32'h14, 32'h18, 1'b0);
    applyStimulus(32'h18, 32'h1C, 1'b0);
    checkOutput("sat_count3", 32'(stepCount2), 32'h3);
    applyStimulus(32'h1C, 32'h20, 1'b0);
    applyStimulus(32'h20, 32'h24, 1'b1);
    checkOutput("sat_hold",  32'(stepCount2), 32'h3);
    checkOutput("sat_done",  32'(done2), 32'h1);
    checkOutput("sat_wide",  stepCount, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
